// File: rtl/fmul_pkg.sv
// Shared types and constants for the GF(2^255-19) multiplier arbiter.
package fmul_pkg;

    localparam int FE_W     = 255;
    localparam int OP_W     = 256;
    localparam int ID_MAX_W = 3;

    // 2^255 - 19: all ones except the low five bits, which are 0b01101.
    localparam logic [FE_W-1:0] P25519 = {{(FE_W-5){1'b1}}, 5'b01101};

    typedef logic [FE_W-1:0] fe_t;
    typedef logic [OP_W-1:0] op_t;

    // Requester ids are sized for the largest supported NUM_REQ (8).
    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } tag_t;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        fe_t                 data;
    } rsp_t;

    localparam int RSP_W = $bits(rsp_t);

endpackage

// File: rtl/fmul_rsp_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; head is valid whenever count is nonzero.
module fmul_rsp_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // The producer cannot stall, so a push that finds no room loses data.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !(pop && !empty)));

endmodule

// File: rtl/fmul_arbiter.sv
// Round-robin share of one fixed-latency GF(2^255-19) multiplier with credit-guarded response FIFO.
// Optional FMUL_ARB_PERF_EN adds saturating issue/stall counters.
module fmul_arbiter
    import fmul_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int MUL_LAT    = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0][OP_W-1:0]   req_a,
    input  logic [NUM_REQ-1:0][OP_W-1:0]   req_b,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
    output logic [FE_W-1:0]                rsp_data,
    output logic [OP_W-1:0]                mul_a,
    output logic [OP_W-1:0]                mul_b,
    input  logic [FE_W-1:0]                mul_result
`ifdef FMUL_ARB_PERF_EN
    ,
    output logic [31:0]                    perf_issue_cnt,
    output logic [31:0]                    perf_stall_cnt
`endif
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);
    localparam int OUT_W = $clog2(FIFO_DEPTH+MUL_LAT+2) + 1;

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    winner;
    logic [NUM_REQ-1:0] grant;
    logic               found;
    tag_t               tag_pipe [MUL_LAT+1];
    logic [CNT_W-1:0]   fifo_cnt;
    logic               fifo_empty;
    logic               fifo_full;
    logic [OUT_W-1:0]   outstanding;
    logic               can_issue;
    logic               accept;
    rsp_t               push_data;
    rsp_t               head;
    logic               unused_id_bits;

    function automatic logic [ID_W-1:0] rr_idx(input int p, input int k);
        return ID_W'((p + k) % NUM_REQ);
    endfunction

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[rr_idx(int'(rr_ptr), k)]) begin
                found                          = 1'b1;
                grant[rr_idx(int'(rr_ptr), k)] = 1'b1;
                winner                         = rr_idx(int'(rr_ptr), k);
            end
        end
    end

    // A pop this cycle is deliberately not credited; the slot frees next cycle.
    always_comb begin
        outstanding = OUT_W'(fifo_cnt);
        for (int k = 0; k <= MUL_LAT; k++) begin
            outstanding = outstanding + OUT_W'(tag_pipe[k].valid);
        end
    end

    assign can_issue = (outstanding < OUT_W'(FIFO_DEPTH));
    assign req_ready = grant & {NUM_REQ{can_issue & rst_n}};
    assign accept    = |req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
            for (int k = 0; k <= MUL_LAT; k++) tag_pipe[k] <= '0;
        end else begin
            tag_pipe[0] <= '{valid: accept, id: ID_MAX_W'(winner)};
            for (int k = 1; k <= MUL_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
            if (accept) begin
                mul_a  <= req_a[winner];
                mul_b  <= req_b[winner];
                rr_ptr <= (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
            end else begin
                mul_a <= '0;
                mul_b <= '0;
            end
        end
    end

    // The oldest tag lines up with the multiplier output for its operands.
    assign push_data = '{id: tag_pipe[MUL_LAT].id, data: mul_result};

    fmul_rsp_fifo #(
        .W     (RSP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tag_pipe[MUL_LAT].valid),
        .push_data (push_data),
        .pop       (rsp_valid & rsp_ready),
        .head      (head),
        .count     (fifo_cnt),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign rsp_valid      = ~fifo_empty;
    assign rsp_id         = rsp_valid ? head.id[ID_W-1:0] : '0;
    assign rsp_data       = rsp_valid ? head.data : '0;
    assign unused_id_bits = ^head.id ^ fifo_full;

`ifdef FMUL_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (accept && perf_issue_cnt != '1)
                perf_issue_cnt <= perf_issue_cnt + 1'b1;
            if (|req_valid && !can_issue && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
        end
    end
`else
    // Counters absent: no extra state or ports.
`endif

endmodule

// File: tb/tb_fmul_arbiter.sv
// Self-checking bench for fmul_arbiter with a behavioural pipelined field multiplier.
// Build with FMUL_ARB_PERF_EN defined to also check the performance counters.
module tb_fmul_arbiter;
    import fmul_pkg::*;

    localparam int NUM_REQ    = 4;
    localparam int MUL_LAT    = 3;
    localparam int FIFO_DEPTH = 8;
    localparam int ID_W       = 2;
    localparam int SB_W       = ID_W + FE_W;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b1;
    logic [NUM_REQ-1:0]           req_valid = '0;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ-1:0][OP_W-1:0] req_a = '0;
    logic [NUM_REQ-1:0][OP_W-1:0] req_b = '0;
    logic                         rsp_valid;
    logic                         rsp_ready = 1'b1;
    logic [ID_W-1:0]              rsp_id;
    fe_t                          rsp_data;
    op_t                          mul_a;
    op_t                          mul_b;
    fe_t                          mul_result;
`ifdef FMUL_ARB_PERF_EN
    logic [31:0]                  perf_issue_cnt;
    logic [31:0]                  perf_stall_cnt;
`endif

    fmul_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .MUL_LAT    (MUL_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result)
`ifdef FMUL_ARB_PERF_EN
        ,
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference arithmetic ----------------
    function automatic fe_t ref_mul(input op_t a, input op_t b);
        logic [511:0] prod;
        prod = 512'(a) * 512'(b);
        return fe_t'(prod % 512'(P25519));
    endfunction

    // Behavioural stand-in for the field multiplier: no reset, MUL_LAT stages.
    fe_t mul_pipe [MUL_LAT];
    always @(posedge clk) begin
        mul_pipe[0] <= ref_mul(mul_a, mul_b);
        for (int k = 1; k < MUL_LAT; k++) mul_pipe[k] <= mul_pipe[k-1];
    end
    assign mul_result = mul_pipe[MUL_LAT-1];

    // ---------------- scoreboard ----------------
    logic [SB_W-1:0] exp_q[$];
    logic [SB_W-1:0] mon_e;
    fe_t             rsp_log[$];
    int              grant_log[$];
    int              checks   = 0;
    int              failures = 0;
    int              acc_cnt  = 0;
    int              rsp_cnt  = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_onehot", 512'($countones(req_ready) <= 1), 1);
            chk("ready_without_valid", 512'(req_ready & ~req_valid), 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_q.push_back({ID_W'(i), ref_mul(req_a[i], req_b[i])});
                    grant_log.push_back(i);
                    acc_cnt++;
                end
            end
            if (rsp_valid && rsp_ready) begin
                rsp_cnt++;
                rsp_log.push_back(rsp_data);
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_id", rsp_id, mon_e[SB_W-1 -: ID_W]);
                    chk("rsp_data", rsp_data, mon_e[FE_W-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        acc_cnt = 0;
        rsp_cnt = 0;
        grant_log.delete();
        rsp_log.delete();
    endtask

    task automatic issue_one(input int id, input op_t a, input op_t b, output int acc_edge);
        req_a[id]     = a;
        req_b[id]     = b;
        req_valid[id] = 1'b1;
        acc_edge      = -1;
        for (int t = 0; t < 50 && acc_edge < 0; t++) begin
            @(negedge clk);
            if (req_ready[id]) acc_edge = cyc + 1;
            @(posedge clk);
            #1;
        end
        req_valid[id] = 1'b0;
        if (acc_edge < 0) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_rsp(output int seen);
        seen = -1;
        for (int t = 0; t < 50 && seen < 0; t++) begin
            @(negedge clk);
            if (rsp_valid) seen = cyc;
        end
        if (seen < 0) chk("rsp_timeout", 0, 1);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 80) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        chk(name, exp_q.size(), 0);
    endtask

    function automatic op_t rand_op();
        op_t v;
        case ($urandom_range(0, 7))
            0:       v = op_t'(P25519) - 1;
            1:       v = '1;
            2:       v = op_t'($urandom_range(0, 1000));
            default: v = {$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom};
        endcase
        return v;
    endfunction

    typedef struct {
        int  id;
        op_t a;
        op_t b;
        fe_t exp_data;
    } vec_t;

    // ---------------- test sequence ----------------
    initial begin
        vec_t               vecs [6];
        op_t                one;
        op_t                all_ones;
        int                 acc_edge;
        int                 seen;
        int                 used;
        logic [NUM_REQ-1:0] got;

        one      = 1;
        all_ones = '1;
        vecs[0] = '{0, 256'd9, 256'd11, 255'd99};
        vecs[1] = '{2, one << 130, one << 125, 255'd19};
        vecs[2] = '{1, op_t'(P25519) - 1, op_t'(P25519) - 1, 255'd1};
        vecs[3] = '{3, op_t'(P25519), 256'd5, 255'd0};
        vecs[4] = '{1, all_ones, 256'd1, 255'd37};
        vecs[5] = '{0, op_t'(P25519) + 1, 256'd12345, 255'd12345};

        // Reset state, with every requester asking.
        req_valid = '1;
        for (int i = 0; i < NUM_REQ; i++) req_a[i] = rand_op();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        repeat (2) @(negedge clk);
        chk("rst_req_ready_clocked", req_ready, 0);
        do_reset();

        // Directed single operations with latency and data from the table.
        for (int v = 0; v < 6; v++) begin
            issue_one(vecs[v].id, vecs[v].a, vecs[v].b, acc_edge);
            wait_rsp(seen);
            chk("vec_latency", seen - acc_edge, MUL_LAT + 1);
            chk("vec_id", rsp_id, vecs[v].id);
            chk("vec_data", rsp_data, vecs[v].exp_data);
            @(posedge clk);
            #1;
        end
        drain("vec_drain");

        // Contention: all four at once from a fresh pointer.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i] = 256'd25;
            req_b[i] = op_t'(35 + i);
        end
        req_valid = '1;
        used = 0;
        while (req_valid != '0 && used < 20) begin
            @(negedge clk);
            got = req_valid & req_ready;
            used++;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~got;
        end
        chk("cont_cycles", used, NUM_REQ);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (k < grant_log.size()) chk("cont_grant_order", grant_log[k], k);
            else chk("cont_grant_missing", 0, 1);
        end
        drain("cont_drain");
        for (int k = 0; k < NUM_REQ; k++) begin
            if (k < rsp_log.size()) chk("cont_rsp_data", rsp_log[k], 875 + 25 * k);
            else chk("cont_rsp_missing", 0, 1);
        end

        // Backpressure: credit must stop issue at exactly FIFO_DEPTH.
        do_reset();
        rsp_ready    = 1'b0;
        req_a[1]     = 256'd2;
        req_b[1]     = 256'd7;
        req_valid[1] = 1'b1;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            got = req_valid & req_ready;
            @(posedge clk);
            #1;
            if (got[1]) req_a[1] = req_a[1] + 1;
        end
        @(negedge clk);
        chk("bp_accepts", acc_cnt, FIFO_DEPTH);
        chk("bp_ready_low", req_ready[1], 0);
        chk("bp_no_rsp", rsp_cnt, 0);
`ifdef FMUL_ARB_PERF_EN
        chk("bp_perf_stall_nonzero", 512'(perf_stall_cnt != 0), 1);
`endif
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            got = req_valid & req_ready;
            @(posedge clk);
            #1;
            if (got[1]) req_a[1] = req_a[1] + 1;
        end
        req_valid = '0;
        chk("bp_resume", 512'(acc_cnt > FIFO_DEPTH), 1);
        drain("bp_drain");
        chk("bp_no_loss", rsp_cnt, acc_cnt);

        // Reset while three operations are in flight.
        do_reset();
        req_a[0]     = 256'd3;
        req_b[0]     = 256'd4;
        req_valid[0] = 1'b1;
        used = 0;
        while (acc_cnt < 3 && used < 20) begin
            @(negedge clk);
            got = req_valid & req_ready;
            used++;
            @(posedge clk);
            #1;
            if (got[0]) req_a[0] = req_a[0] + 1;
        end
        chk("mid_accepts", acc_cnt, 3);
        req_valid = '1;
        rst_n     = 1'b0;
        #1;
        chk("mid_req_ready", req_ready, 0);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_rsp_id", rsp_id, 0);
        chk("mid_rsp_data", rsp_data, 0);
        chk("mid_mul_a", mul_a, 0);
        chk("mid_mul_b", mul_b, 0);
        do_reset();
        repeat (12) @(posedge clk);
        #1;
        chk("mid_no_stale", rsp_cnt, 0);
        issue_one(0, 256'd9, 256'd11, acc_edge);
        wait_rsp(seen);
        chk("mid_after_latency", seen - acc_edge, MUL_LAT + 1);
        chk("mid_after_id", rsp_id, 0);
        chk("mid_after_data", rsp_data, 99);
        drain("mid_drain");

        // Full throughput with random requesters and operands.
        do_reset();
        got  = '0;
        used = 0;
        while (acc_cnt < 100 && used < 400) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || got[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    req_a[i]     = rand_op();
                    req_b[i]     = rand_op();
                end
            end
            if (req_valid == '0) req_valid[$urandom_range(0, NUM_REQ-1)] = 1'b1;
            @(negedge clk);
            got = req_valid & req_ready;
            used++;
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        chk("tp_accepts", acc_cnt, 100);
        chk("tp_cycles", used, 100);
        drain("tp_drain");
        chk("tp_rsp_count", rsp_cnt, 100);
`ifdef FMUL_ARB_PERF_EN
        chk("tp_perf_issue", perf_issue_cnt, 100);
        chk("tp_perf_stall", perf_stall_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
